max7219_receiver: RTL and testbench

Serial-side responder for the MAX7219 display protocol: samples the three-wire DIN/CLK/LOAD stream that our display driver emits and decodes each 16-bit frame. It reproduces the MAX7219 register file: 8 digit registers plus decode-mode, intensity, scan-limit, shutdown and display-test. It exposes that register file to on-chip logic and to the verification bench. It sits at the far end of the display driver's serial output, either as an on-die display emulator or as the bench checker, and provides a daisy-chain DOUT.

---
 rtl/max7219_receiver.sv | 141 ++++++++++++++
 tb/tb_max7219_receiver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_receiver.sv
// MAX7219 serial-side responder: synchronizes DIN/CLK/LOAD, decodes 16-bit frames
// into the MAX7219 register file and drives the daisy-chain DOUT.
`timescale 1ns/1ps
module max7219_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_serial_din,
  input  logic       i_serial_clk,
  input  logic       i_serial_load,
  output logic       o_serial_dout,
  output logic       o_stb,
  output logic [3:0] o_addr,
  output logic [7:0] o_data,
  output logic       o_frame_err,
  input  logic [2:0] i_rd_digit,
  output logic [7:0] o_rd_segment,
  output logic [7:0] o_decode_mode,
  output logic [3:0] o_intensity,
  output logic [2:0] o_scan_limit,
  output logic       o_enable,
  output logic       o_display_test
);

  // SYNC_STAGES synchronizer flops, one sample flop and one history flop per
  // edge-detected input; DIN needs no history, only matching delay.
  localparam int PIPE = SYNC_STAGES + 2;

  logic [PIPE-1:0] clk_pipe_q;
  logic [PIPE-1:0] load_pipe_q;
  logic [PIPE-2:0] din_pipe_q;

  logic        clk_rise, clk_fall, load_rise, load_fall, load_prev, din_s;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d, shifted_cnt;
  logic        frame_valid;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;

  logic [7:0]  digit_q [8];
  logic [7:0]  decode_q;
  logic [3:0]  intensity_q;
  logic [2:0]  scan_q;
  logic        enable_q, test_q;
  logic [3:0]  addr_q;
  logic [7:0]  data_q;
  logic        stb_q, err_q, dout_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain shift.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      clk_pipe_q  <= '0;
      load_pipe_q <= '1;
      din_pipe_q  <= '0;
    end else begin
      clk_pipe_q  <= {clk_pipe_q[PIPE-2:0], i_serial_clk};
      load_pipe_q <= {load_pipe_q[PIPE-2:0], i_serial_load};
      din_pipe_q  <= {din_pipe_q[PIPE-3:0], i_serial_din};
    end
  end

  assign clk_rise  =  clk_pipe_q[PIPE-2]  & ~clk_pipe_q[PIPE-1];
  assign clk_fall  = ~clk_pipe_q[PIPE-2]  &  clk_pipe_q[PIPE-1];
  assign load_rise =  load_pipe_q[PIPE-2] & ~load_pipe_q[PIPE-1];
  assign load_fall = ~load_pipe_q[PIPE-2] &  load_pipe_q[PIPE-1];
  assign load_prev =  load_pipe_q[PIPE-1];
  assign din_s     =  din_pipe_q[PIPE-2];

  // Shift before evaluating, so a clk rise coinciding with the LOAD rise is
  // counted in the frame; gating on the previous LOAD level makes that legal.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    shift_d     = shift_q;
    shifted_cnt = bit_cnt_q;
    if (clk_rise && !load_prev) begin
      shift_d = {shift_q[14:0], din_s};
      if (bit_cnt_q != 5'd31) shifted_cnt = bit_cnt_q + 5'd1;
    end
    frame_valid = shifted_cnt >= 5'd16;
    bit_cnt_d   = (load_rise || load_fall) ? 5'd0 : shifted_cnt;
  end

  assign wr_addr = shift_d[11:8];
  assign wr_data = shift_d[7:0];

  // NOTE: the register file is reset explicitly; it is only a few flops and the
  // display must come up blank and in shutdown.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      dout_q      <= 1'b0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      enable_q    <= 1'b0;
      test_q      <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      stb_q     <= load_rise &&  frame_valid;
      err_q     <= load_rise && !frame_valid;
      if (clk_fall) dout_q <= shift_q[15];
      if (load_rise && frame_valid) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
        for (int i = 0; i < 8; i++)
          if (wr_addr == 4'(i + 1)) digit_q[i] <= wr_data;
        case (wr_addr)
          4'h9:    decode_q    <= wr_data;
          4'hA:    intensity_q <= wr_data[3:0];
          4'hB:    scan_q      <= wr_data[2:0];
          4'hC:    enable_q    <= wr_data[0];
          4'hF:    test_q      <= wr_data[0];
          default: ;
        endcase
      end
    end
  end

  assign o_serial_dout  = dout_q;
  assign o_stb          = stb_q;
  assign o_frame_err    = err_q;
  assign o_addr         = addr_q;
  assign o_data         = data_q;
  assign o_rd_segment   = digit_q[i_rd_digit];
  assign o_decode_mode  = decode_q;
  assign o_intensity    = intensity_q;
  assign o_scan_limit   = scan_q;
  assign o_enable       = enable_q;
  assign o_display_test = test_q;

endmodule

// File: tb/tb_max7219_receiver.sv
// Bench for max7219_receiver: pin-level serial stimulus, frame-level reference
// model with a per-cycle compare process, plus literal checks of the scenarios.
`timescale 1ns/1ps
module tb_max7219_receiver;

  localparam int LAT = 4;  // pin drive to visible output, in posedges

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_serial_din = 1'b0, i_serial_clk = 1'b0, i_serial_load = 1'b1;
  logic [2:0] i_rd_digit = 3'd0;
  logic       o_serial_dout, o_stb, o_frame_err, o_enable, o_display_test;
  logic [3:0] o_addr, o_intensity;
  logic [7:0] o_data, o_rd_segment, o_decode_mode;
  logic [2:0] o_scan_limit;

  always #5 clk = ~clk;

  max7219_receiver #(.SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_serial_din(i_serial_din), .i_serial_clk(i_serial_clk), .i_serial_load(i_serial_load),
    .o_serial_dout(o_serial_dout), .o_stb(o_stb), .o_addr(o_addr), .o_data(o_data),
    .o_frame_err(o_frame_err), .i_rd_digit(i_rd_digit), .o_rd_segment(o_rd_segment),
    .o_decode_mode(o_decode_mode), .o_intensity(o_intensity), .o_scan_limit(o_scan_limit),
    .o_enable(o_enable), .o_display_test(o_display_test)
  );

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scheduled effects of pin activity, tagged with the posedge they become visible.
  typedef struct {
    int          cyc;
    bit          is_dout;
    bit          ok;
    logic [15:0] word;
    int          tag;
  } ev_t;
  ev_t evq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver-side view of the serial stream: last 16 bits shifted, bits in frame.
  logic [15:0] d_sr = '0;
  int          d_cnt = 0, fall_no = 0, load_rise_cyc = 0;

  // Applied model state.
  logic [7:0] m_dig [8];
  logic [7:0] m_dec, m_data;
  logic [3:0] m_int, m_addr;
  logic [2:0] m_scan;
  logic       m_en, m_test, m_dout;

  int          stb_cnt = 0, err_cnt = 0, stb_cyc = 0;
  bit          cap_en = 0, rd_hold = 0;
  logic [15:0] dout_cap = '0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    m_dec = '0; m_int = '0; m_scan = '0; m_en = 0; m_test = 0;
    m_addr = '0; m_data = '0; m_dout = 0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    m_addr = a; m_data = d;
    if (a >= 4'd1 && a <= 4'd8) m_dig[a - 4'd1] = d;
    else if (a == 4'h9) m_dec = d;
    else if (a == 4'hA) m_int = d[3:0];
    else if (a == 4'hB) m_scan = d[2:0];
    else if (a == 4'hC) m_en = d[0];
    else if (a == 4'hF) m_test = d[0];
  endtask

  logic rst_at;
  always @(posedge clk) begin
    logic exp_stb, exp_err;
    ev_t  ev;
    rst_at = i_reset_n;
    #1;
    exp_stb = 0; exp_err = 0;
    if (!rst_at) begin
      model_reset();
      evq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        if (ev.is_dout) begin
          m_dout = ev.word[0];
          if (cap_en && ev.tag >= 16 && ev.tag <= 31) dout_cap = {dout_cap[14:0], o_serial_dout};
        end else if (ev.ok) begin
          model_write(ev.word[11:8], ev.word[7:0]);
          exp_stb = 1;
        end else begin
          exp_err = 1;
        end
      end
    end
    check("stb", o_stb, exp_stb);
    check("frame_err", o_frame_err, exp_err);
    check("addr", o_addr, m_addr);
    check("data", o_data, m_data);
    check("rd_segment", o_rd_segment, m_dig[i_rd_digit]);
    check("decode_mode", o_decode_mode, m_dec);
    check("intensity", o_intensity, m_int);
    check("scan_limit", o_scan_limit, m_scan);
    check("enable", o_enable, m_en);
    check("display_test", o_display_test, m_test);
    check("serial_dout", o_serial_dout, m_dout);
    if (o_stb) begin stb_cnt++; stb_cyc = cyc; end
    if (o_frame_err) err_cnt++;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rd_hold) i_rd_digit = 3'($urandom_range(0, 7));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin_clk(input logic v);
    ev_t ev;
    if (v && !i_serial_clk && !i_serial_load) begin
      d_sr = {d_sr[14:0], i_serial_din};
      if (d_cnt < 31) d_cnt++;
    end
    if (!v && i_serial_clk) begin
      fall_no++;
      ev = '{cyc: cyc + LAT, is_dout: 1'b1, ok: 1'b0, word: {15'd0, d_sr[15]}, tag: fall_no};
      evq.push_back(ev);
    end
    i_serial_clk = v;
  endtask

  task automatic pin_load(input logic v);
    ev_t ev;
    if (!v && i_serial_load) begin
      d_cnt = 0; fall_no = 0;
    end
    if (v && !i_serial_load) begin
      ev = '{cyc: cyc + LAT, is_dout: 1'b0, ok: (d_cnt >= 16), word: d_sr, tag: 0};
      evq.push_back(ev);
      load_rise_cyc = cyc;
      d_cnt = 0;
    end
    i_serial_load = v;
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      i_serial_din = bits[i];
      wait_cyc(half);
      pin_clk(1'b1);
      wait_cyc(half);
      pin_clk(1'b0);
    end
  endtask

  task automatic frame(input logic [63:0] bits, input int n, input int half);
    pin_load(1'b0);
    wait_cyc(3);
    send_bits(bits, n, half);
    wait_cyc(2);
    pin_load(1'b1);
    wait_cyc(8);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    d_sr = '0; d_cnt = 0; fall_no = 0;
    wait_cyc(3);
    i_reset_n = 1'b1;
  endtask

  task automatic read_digit(input int idx, input logic [7:0] exp, input string name);
    rd_hold = 1;
    i_rd_digit = 3'(idx);
    @(posedge clk); #2;
    check(name, o_rd_segment, exp);
    rd_hold = 0;
  endtask

  int s0, e0;

  initial begin
    model_reset();
    wait_cyc(3);
    i_reset_n = 1'b1;
    wait_cyc(6);
    check("reset_enable", o_enable, 1'b0);
    check("reset_addr", o_addr, 4'h0);
    read_digit(5, 8'h00, "reset_digit5");

    // Digit write
    s0 = stb_cnt;
    frame(64'h0305, 16, 4);
    check("digit_stb_count", stb_cnt - s0, 1);
    check("digit_addr", o_addr, 4'h3);
    check("digit_data", o_data, 8'h05);
    read_digit(2, 8'h05, "digit2_written");
    read_digit(3, 8'h00, "digit3_untouched");

    // Config sequence
    s0 = stb_cnt;
    frame(64'h09FF, 16, 4);
    frame(64'h0A07, 16, 4);
    frame(64'h0B05, 16, 4);
    frame(64'h0C01, 16, 4);
    frame(64'h0F00, 16, 4);
    check("cfg_stb_count", stb_cnt - s0, 5);
    check("cfg_decode", o_decode_mode, 8'hFF);
    check("cfg_intensity", o_intensity, 4'h7);
    check("cfg_scan", o_scan_limit, 3'd5);
    check("cfg_enable", o_enable, 1'b1);
    check("cfg_test", o_display_test, 1'b0);

    // Short frame
    s0 = stb_cnt; e0 = err_cnt;
    frame(64'hABC, 12, 4);
    check("short_err_count", err_cnt - e0, 1);
    check("short_stb_count", stb_cnt - s0, 0);
    check("short_addr_hold", o_addr, 4'hF);
    check("short_data_hold", o_data, 8'h00);
    check("short_intensity", o_intensity, 4'h7);

    // Daisy chain
    cap_en = 1;
    frame({32'd0, 16'h0102, 16'h0811}, 32, 4);
    cap_en = 0;
    read_digit(7, 8'h11, "daisy_digit7");
    read_digit(0, 8'h00, "daisy_digit0");
    check("daisy_dout_replay", dout_cap, 16'h0102);

    // Gating: clk pulses with LOAD high are ignored
    frame(64'h0C00, 16, 4);
    check("gate_enable_off", o_enable, 1'b0);
    send_bits(64'h1F, 5, 4);
    wait_cyc(6);
    frame(64'h0C01, 16, 4);
    check("gate_enable_on", o_enable, 1'b1);

    // Reset mid-frame
    pin_load(1'b0);
    wait_cyc(3);
    send_bits(64'hC0, 8, 4);
    wait_cyc(2);
    do_reset();
    wait_cyc(6);
    e0 = err_cnt;
    pin_load(1'b1);
    wait_cyc(8);
    check("rst_mid_err", err_cnt - e0, 1);
    check("rst_mid_enable", o_enable, 1'b0);

    // Minimum phase width and latency
    frame(64'h0AFF, 16, 3);
    check("min_phase_intensity", o_intensity, 4'hF);
    check("stb_latency", stb_cyc - load_rise_cyc, LAT);

    // Randomized frames, lengths and gated pulses
    for (int it = 0; it < 40; it++) begin
      int n, half;
      logic [63:0] bits;
      bits = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       n = $urandom_range(1, 15);
        1:       n = $urandom_range(17, 40);
        default: n = 16;
      endcase
      half = $urandom_range(3, 5);
      if ($urandom_range(0, 4) == 0) begin
        send_bits(bits >> 40, 3, half);
        wait_cyc(4);
      end
      frame(bits, n, half);
    end
    wait_cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
